// File: rtl/bulls_cows_pkg.sv
// Shared constants, FSM state type and LFSR step for the Bulls-and-Cows game controller.
package bulls_cows_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned DIGIT_MAX  = 9;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    ENTRY,
    CHECK,
    WIN,
    LOSE
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bulls_cows_game_ctrl_if.sv
// Scorer link: the controller drives guess/answer/check_enable, the scorer answers strike/ball.
interface bulls_cows_game_ctrl_if;
  logic [15:0] guess;
  logic [15:0] answer;
  logic        check_enable;
  logic [3:0]  strike;
  logic [3:0]  ball;

  modport master (output guess, answer, check_enable, input strike, ball);
  modport slave  (input guess, answer, check_enable, output strike, ball);
endinterface

// File: rtl/bulls_cows_secret_gen.sv
// Free-running LFSR plus a filter that keeps only unused BCD digits until four are collected.
module bulls_cows_secret_gen
  import bulls_cows_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gen_start,
  output logic [15:0] answer,
  output logic        gen_done
);

  logic [15:0] lfsr;
  logic [15:0] used;
  logic [2:0]  cnt;
  logic        active;
  logic [3:0]  cand;
  logic        accept;

  assign cand = lfsr[3:0];

  always_comb begin
    accept = 1'b0;
    if (active && (cand <= 4'(DIGIT_MAX))) accept = !used[cand];
    gen_done = accept && (cnt == 3'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= LFSR_SEED;
      used   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      answer <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (gen_start) begin
        used   <= '0;
        cnt    <= '0;
        active <= 1'b1;
        answer <= '0;
      end else if (accept) begin
        // nibble index 3-cnt: first accepted digit lands in [15:12]
        answer[{~cnt[1:0], 2'b00} +: 4] <= cand;
        used[cand] <= 1'b1;
        cnt        <= cnt + 3'd1;
        if (gen_done) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bulls_cows_game_ctrl.sv
// Game controller: secret generation, guess entry, scoring handshake, attempt counting, win/lose.
module bulls_cows_game_ctrl
  import bulls_cows_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic                  clear,
  input  logic                  submit,
  bulls_cows_game_ctrl_if.master sc,
  output logic [2:0]            digit_count,
  output logic                  entry_error,
  output logic                  result_valid,
  output logic [3:0]            last_strike,
  output logic [3:0]            last_ball,
  output logic [3:0]            attempts,
  output logic                  win,
  output logic                  lose,
  output logic                  busy
);

  state_t      state, state_n;
  logic        gen_start, gen_done;
  logic [15:0] guess_r, answer_w;
  logic        dup, accept_digit, do_clear, err_n;
  logic [3:0]  attempts_inc;

  bulls_cows_secret_gen #(.LFSR_SEED(LFSR_SEED)) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .gen_start(gen_start),
    .answer   (answer_w),
    .gen_done (gen_done)
  );

  assign sc.answer       = answer_w;
  assign sc.guess        = guess_r;
  assign sc.check_enable = (state == CHECK);
  assign busy            = (state == GEN) || (state == CHECK);
  assign win             = (state == WIN);
  assign lose            = (state == LOSE);
  assign attempts_inc    = (attempts == 4'hF) ? attempts : attempts + 4'd1;

  always_comb begin
    dup = ((digit_count > 3'd0) && (guess_r[15:12] == digit)) ||
          ((digit_count > 3'd1) && (guess_r[11:8]  == digit)) ||
          ((digit_count > 3'd2) && (guess_r[7:4]   == digit)) ||
          ((digit_count > 3'd3) && (guess_r[3:0]   == digit));
  end

  always_comb begin
    state_n      = state;
    gen_start    = 1'b0;
    accept_digit = 1'b0;
    do_clear     = 1'b0;
    err_n        = 1'b0;
    if (start && (state != GEN)) begin
      state_n   = GEN;
      gen_start = 1'b1;
    end else begin
      unique case (state)
        GEN:   if (gen_done) state_n = ENTRY;
        ENTRY: begin
          if (clear) begin
            do_clear = 1'b1;
          end else if (submit) begin
            if (digit_count == 3'(NUM_DIGITS)) state_n = CHECK;
            else                               err_n   = 1'b1;
          end else if (digit_valid) begin
            if ((digit > 4'(DIGIT_MAX)) || dup || (digit_count == 3'(NUM_DIGITS)))
              err_n = 1'b1;
            else
              accept_digit = 1'b1;
          end
        end
        CHECK: begin
          if (sc.strike == 4'(NUM_DIGITS))             state_n = WIN;
          else if (attempts_inc == MAX_TRIES[3:0])     state_n = LOSE;
          else                                         state_n = ENTRY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guess_r      <= '0;
      digit_count  <= '0;
      entry_error  <= 1'b0;
      result_valid <= 1'b0;
      last_strike  <= '0;
      last_ball    <= '0;
      attempts     <= '0;
    end else begin
      entry_error  <= err_n;
      result_valid <= 1'b0;
      if (gen_start) begin
        guess_r     <= '0;
        digit_count <= '0;
        last_strike <= '0;
        last_ball   <= '0;
        attempts    <= '0;
      end else begin
        if (do_clear) begin
          guess_r     <= '0;
          digit_count <= '0;
        end
        if (accept_digit) begin
          guess_r[{~digit_count[1:0], 2'b00} +: 4] <= digit;
          digit_count <= digit_count + 3'd1;
        end
        // guess stays visible after scoring until the next entry overwrites it
        if (state == CHECK) begin
          last_strike  <= sc.strike;
          last_ball    <= sc.ball;
          result_valid <= 1'b1;
          attempts     <= attempts_inc;
          digit_count  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// Directed-plus-random bench; acts as the scorer and predicts the secret from its own LFSR model.
module tb_bulls_cows_game_ctrl;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          TRIES = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, digit_valid = 1'b0, clear = 1'b0, submit = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [2:0] digit_count;
  logic entry_error, result_valid, win, lose, busy;
  logic [3:0] last_strike, last_ball, attempts;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_ans;
  int          m_len;

  bulls_cows_game_ctrl_if ifc();

  bulls_cows_game_ctrl #(.MAX_TRIES(TRIES), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid), .digit(digit),
    .clear(clear), .submit(submit), .sc(ifc.master), .digit_count(digit_count),
    .entry_error(entry_error), .result_valid(result_valid), .last_strike(last_strike),
    .last_ball(last_ball), .attempts(attempts), .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] poly_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= poly_step(m_lfsr);

  function automatic int nib(input logic [15:0] v, input int i);
    return int'((v >> (4 * (3 - i))) & 16'hF);
  endfunction

  function automatic void score(input logic [15:0] g, input logic [15:0] a,
                                output int s, output int b);
    s = 0;
    b = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (nib(g, i) == nib(a, j)) begin
          if (i == j) s++;
          else        b++;
        end
  endfunction

  always_comb begin
    int s, b;
    s = 0;
    b = 0;
    if (ifc.check_enable) score(ifc.guess, ifc.answer, s, b);
    ifc.strike = 4'(s);
    ifc.ball   = 4'(b);
  end

  function automatic logic valid_secret(input logic [15:0] a);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (nib(a, i) > 9) ok = 1'b0;
      for (int j = i + 1; j < 4; j++) if (nib(a, i) == nib(a, j)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // walk the LFSR sequence from the first GEN cycle to find the secret and GEN length
  task automatic predict();
    logic [15:0] m;
    logic [9:0]  used;
    int          cnt;
    m = m_lfsr;
    used = '0;
    cnt = 0;
    m_ans = '0;
    m_len = 0;
    while (cnt < 4 && m_len < 1000) begin
      if (m[3:0] <= 4'd9 && !used[m[3:0]]) begin
        used[m[3:0]] = 1'b1;
        m_ans = m_ans | (16'(m[3:0]) << (4 * (3 - cnt)));
        cnt++;
      end
      m = poly_step(m);
      m_len++;
    end
  endtask

  task automatic start_game(input logic with_submit);
    int k;
    start = 1'b1;
    submit = with_submit;
    tick();
    start = 1'b0;
    submit = 1'b0;
    predict();
    chk("gen_busy", busy, 1);
    chk("gen_no_chk", ifc.check_enable, 0);
    chk("gen_win", win, 0);
    chk("gen_lose", lose, 0);
    chk("gen_attempts", attempts, 0);
    chk("gen_dcount", digit_count, 0);
    chk("gen_guess", ifc.guess, 0);
    chk("gen_last_strike", last_strike, 0);
    k = 0;
    while (busy && k < 300) begin
      digit_valid = 1'b1;
      digit = 4'd1;
      tick();
      k++;
    end
    digit_valid = 1'b0;
    chk("gen_len", k, m_len);
    chk("gen_answer", ifc.answer, m_ans);
    chk("gen_secret_ok", valid_secret(ifc.answer), 1);
    chk("gen_ignored_keys", digit_count, 0);
  endtask

  task automatic key(input logic [3:0] d, input logic exp_err, input logic [2:0] exp_dc);
    digit_valid = 1'b1;
    digit = d;
    tick();
    digit_valid = 1'b0;
    chk("key_err", entry_error, exp_err);
    chk("key_dcount", digit_count, exp_dc);
  endtask

  task automatic submit_guess(input logic [15:0] g, input logic [3:0] exp_att);
    int s, b;
    for (int i = 0; i < 4; i++) key(4'(nib(g, i)), 1'b0, 3'(i + 1));
    submit = 1'b1;
    tick();
    submit = 1'b0;
    chk("sub_chk_en", ifc.check_enable, 1);
    chk("sub_busy", busy, 1);
    chk("sub_no_rv", result_valid, 0);
    score(g, m_ans, s, b);
    tick();
    chk("res_valid", result_valid, 1);
    chk("res_strike", last_strike, s);
    chk("res_ball", last_ball, b);
    chk("res_attempts", attempts, exp_att);
    chk("res_dcount", digit_count, 0);
    chk("res_guess_held", ifc.guess, g);
    chk("res_chk_en_low", ifc.check_enable, 0);
    chk("res_win", win, (s == 4));
    chk("res_lose", lose, (s != 4) && (int'(exp_att) == TRIES));
    tick();
    chk("res_valid_pulse", result_valid, 0);
  endtask

  function automatic logic [15:0] wrong_guess(input logic [15:0] a);
    logic [15:0] g;
    int cnt;
    logic hit;
    g = '0;
    cnt = 0;
    for (int d = 0; d < 10; d++) begin
      hit = 1'b0;
      for (int j = 0; j < 4; j++) if (nib(a, j) == d) hit = 1'b1;
      if (!hit && cnt < 4) begin
        g = g | (16'(d) << (4 * (3 - cnt)));
        cnt++;
      end
    end
    return g;
  endfunction

  function automatic logic [15:0] rand_guess(input logic [15:0] a);
    int p[10];
    int t, r, s, b;
    logic [15:0] g;
    for (int i = 0; i < 10; i++) p[i] = i;
    for (int i = 9; i > 0; i--) begin
      r = int'($urandom_range(i, 0));
      t = p[i];
      p[i] = p[r];
      p[r] = t;
    end
    score({4'(p[0]), 4'(p[1]), 4'(p[2]), 4'(p[3])}, a, s, b);
    if (s == 4) begin
      t = p[0];
      p[0] = p[1];
      p[1] = t;
    end
    g = {4'(p[0]), 4'(p[1]), 4'(p[2]), 4'(p[3])};
    return g;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_guess", ifc.guess, 0);
    chk("rst_answer", ifc.answer, 0);
    chk("rst_chk_en", ifc.check_enable, 0);
    chk("rst_dcount", digit_count, 0);
    chk("rst_err", entry_error, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_strike", last_strike, 0);
    chk("rst_ball", last_ball, 0);
    chk("rst_attempts", attempts, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    logic [15:0] perm, wg;
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (int'($urandom_range(20, 1))) tick();
    check_reset_outputs();

    // game 1: entry errors, then permutation, random guess, winning guess on the last try
    start_game(1'b0);
    perm = {m_ans[11:0], m_ans[15:12]};
    wg = wrong_guess(m_ans);
    key(m_ans[15:12], 1'b0, 3'd1);
    key(m_ans[15:12], 1'b1, 3'd1);
    key(4'd12, 1'b1, 3'd1);
    clear = 1'b1;
    digit_valid = 1'b1;
    digit = m_ans[11:8];
    tick();
    clear = 1'b0;
    digit_valid = 1'b0;
    chk("clear_vs_digit_dc", digit_count, 0);
    chk("clear_vs_digit_guess", ifc.guess, 0);
    key(m_ans[15:12], 1'b0, 3'd1);
    key(m_ans[11:8], 1'b0, 3'd2);
    key(m_ans[7:4], 1'b0, 3'd3);
    submit = 1'b1;
    tick();
    submit = 1'b0;
    chk("short_submit_err", entry_error, 1);
    chk("short_submit_no_chk", ifc.check_enable, 0);
    chk("short_submit_dc", digit_count, 3);
    key(m_ans[3:0], 1'b0, 3'd4);
    key(wg[15:12], 1'b1, 3'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_dc", digit_count, 0);
    submit_guess(perm, 4'd1);
    chk("perm_back_entry", busy, 0);
    submit_guess(rand_guess(m_ans), 4'd2);
    submit_guess(m_ans, 4'd3);
    key(4'd3, 1'b0, 3'd0);
    chk("win_held", win, 1);

    // game 2: run out of tries, then keys are ignored in LOSE
    start_game(1'b0);
    submit_guess(wrong_guess(m_ans), 4'd1);
    submit_guess(rand_guess(m_ans), 4'd2);
    submit_guess({m_ans[11:0], m_ans[15:12]}, 4'd3);
    key(4'd2, 1'b0, 3'd0);
    chk("lose_held", lose, 1);

    // game 3: start+submit together restarts; reset in CHECK
    start_game(1'b0);
    for (int i = 0; i < 4; i++) key(4'(nib(m_ans, i)), 1'b0, 3'(i + 1));
    start_game(1'b1);
    submit_guess(wrong_guess(m_ans), 4'd1);
    for (int i = 0; i < 4; i++) key(4'(nib(m_ans, i)), 1'b0, 3'(i + 1));
    submit = 1'b1;
    tick();
    submit = 1'b0;
    chk("pre_rst_chk_en", ifc.check_enable, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_win", win, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
